// File: rtl/lector_salidas_pkg.sv
// Types and constants shared by the output-FIFO reader and the input arbiter.
package lector_salidas_pkg;
    localparam int DEF_DATA_W = 6;
    localparam int DEF_CNT_W  = 8;
    localparam int N_FIFO     = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        POP     = 2'd1,
        CAPTURE = 2'd2,
        SEND    = 2'd3
    } estado_t;

    // FIFO index 0..3 corresponds to output ports 4..7
    localparam logic [1:0] IDX_F4 = 2'd0;
    localparam logic [1:0] IDX_F5 = 2'd1;
    localparam logic [1:0] IDX_F6 = 2'd2;
    localparam logic [1:0] IDX_F7 = 2'd3;
endpackage

// File: rtl/lector_salidas_if.sv
// FIFO read side (ports 4..7), delivered-word stream and debug counters.
interface lector_salidas_if
    import lector_salidas_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) ();
    logic              empty4, empty5, empty6, empty7;
    logic [DATA_W-1:0] data4, data5, data6, data7;
    logic              pop4, pop5, pop6, pop7;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic              out_ready;
    logic [1:0]        origen;
    logic [CNT_W-1:0]  cnt4, cnt5, cnt6, cnt7;

    modport master (
        input  empty4, empty5, empty6, empty7,
        input  data4, data5, data6, data7,
        input  out_ready,
        output pop4, pop5, pop6, pop7,
        output data_out, valid_out, origen,
        output cnt4, cnt5, cnt6, cnt7
    );

    modport slave (
        output empty4, empty5, empty6, empty7,
        output data4, data5, data6, data7,
        output out_ready,
        input  pop4, pop5, pop6, pop7,
        input  data_out, valid_out, origen,
        input  cnt4, cnt5, cnt6, cnt7
    );
endinterface

// File: rtl/rr_prioridad4.sv
// Combinational 4-way round-robin picker: first request after i_ultimo, wrapping.
module rr_prioridad4
    import lector_salidas_pkg::*;
(
    input  logic [N_FIFO-1:0] i_req,
    input  logic [1:0]        i_ultimo,
    output logic [1:0]        o_grant,
    output logic              o_any_req
);
    logic [1:0] w_idx;

    // Scan from farthest to nearest so the nearest requester wins the last write
    always_comb begin
        o_grant = i_ultimo;
        w_idx   = i_ultimo;
        for (int i = N_FIFO; i >= 1; i--) begin
            w_idx = i_ultimo + 2'(i);
            if (i_req[w_idx]) o_grant = w_idx;
        end
    end

    assign o_any_req = |i_req;
endmodule

// File: rtl/lector_salidas.sv
// Drains output FIFOs 4..7 round-robin, one word per transaction, onto a
// registered valid/ready stream tagged with its source FIFO.
module lector_salidas
    import lector_salidas_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    lector_salidas_if.master bus
);
    estado_t                        r_state, w_next;
    logic [1:0]                     r_sel, r_ultimo, r_origen, w_grant;
    logic                           w_any, w_hs, r_valid;
    logic [DATA_W-1:0]              r_data;
    logic [N_FIFO-1:0][CNT_W-1:0]   r_cnt;
    logic [N_FIFO-1:0][DATA_W-1:0]  w_data;
    logic [N_FIFO-1:0]              w_req, w_pop;

    assign w_req  = ~{bus.empty7, bus.empty6, bus.empty5, bus.empty4};
    assign w_data = {bus.data7, bus.data6, bus.data5, bus.data4};

    rr_prioridad4 u_rr (
        .i_req     (w_req),
        .i_ultimo  (r_ultimo),
        .o_grant   (w_grant),
        .o_any_req (w_any)
    );

    assign w_hs = (r_state == SEND) && r_valid && bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_next = POP;
            POP:     w_next = CAPTURE;
            CAPTURE: w_next = SEND;
            SEND:    if (w_hs) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Grant is frozen in r_sel at the IDLE decision; later empty changes are ignored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel    <= IDX_F4;
            r_ultimo <= IDX_F7;
            r_data   <= '0;
            r_origen <= '0;
            r_valid  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            if (r_state == IDLE && w_any) r_sel <= w_grant;
            if (r_state == CAPTURE) begin
                r_data   <= w_data[r_sel];
                r_origen <= r_sel;
                r_valid  <= 1'b1;
            end
            if (w_hs) begin
                r_valid        <= 1'b0;
                r_cnt[r_sel]   <= r_cnt[r_sel] + CNT_W'(1);
                r_ultimo       <= r_sel;
            end
        end
    end

    // Pops decode from registered state only, so reset drops them immediately
    always_comb begin
        w_pop = '0;
        if (r_state == POP) w_pop[r_sel] = 1'b1;
    end

    assign bus.pop4      = w_pop[0];
    assign bus.pop5      = w_pop[1];
    assign bus.pop6      = w_pop[2];
    assign bus.pop7      = w_pop[3];
    assign bus.data_out  = r_data;
    assign bus.valid_out = r_valid;
    assign bus.origen    = r_origen;
    assign bus.cnt4      = r_cnt[0];
    assign bus.cnt5      = r_cnt[1];
    assign bus.cnt6      = r_cnt[2];
    assign bus.cnt7      = r_cnt[3];
endmodule

// File: tb/tb_lector_salidas.sv
// Random/directed bench for lector_salidas with FIFO models and a scoreboard.
module tb_lector_salidas;
    import lector_salidas_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b0;
    always #5 clk = ~clk;

    lector_salidas_if bus ();
    lector_salidas dut (.clk(clk), .rst(rst), .bus(bus));

    logic [5:0] fq   [4][$];
    logic [5:0] expq [4][$];
    logic [3:0] emp = 4'hF;
    logic [5:0] rd [4];

    wire [3:0]      popv = {bus.pop7, bus.pop6, bus.pop5, bus.pop4};
    wire [3:0][7:0] cntv = {bus.cnt7, bus.cnt6, bus.cnt5, bus.cnt4};

    assign bus.empty4 = emp[0];
    assign bus.empty5 = emp[1];
    assign bus.empty6 = emp[2];
    assign bus.empty7 = emp[3];
    assign bus.data4  = rd[0];
    assign bus.data5  = rd[1];
    assign bus.data6  = rd[2];
    assign bus.data7  = rd[3];
    assign bus.out_ready = rdy;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // FIFO storage with registered read: data appears the cycle after pop
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++)
            if (popv[k] && fq[k].size() > 0) rd[k] <= fq[k].pop_front();
        emp <= {fq[3].size() == 0, fq[2].size() == 0, fq[1].size() == 0, fq[0].size() == 0};
    end

    // Reference: next grant is the first requester after the last delivered one
    function automatic int rr_pick(int lst, logic [3:0] req);
        for (int d = 1; d <= 4; d++)
            if (req[(lst + d) % 4]) return (lst + d) % 4;
        return -1;
    endfunction

    int         last = 3;
    int         inf_k = 0;
    logic [5:0] inf_w = '0;
    bit         have_inf = 0;
    logic [3:0] preq = '0;
    bit         pvld = 0, phs = 0;
    logic [5:0] pdata = '0;
    logic [1:0] porig = '0;
    logic [7:0] mcnt [4] = '{default: 8'd0};
    int         deliv = 0, npops = 0;
    int         olog [$];

    always @(negedge clk) begin
        if (rst) begin
            last = 3; have_inf = 0; pvld = 0; phs = 0;
            for (int k = 0; k < 4; k++) mcnt[k] = 8'd0;
        end else begin
            if (popv != 4'b0) begin
                int g, pk;
                logic [3:0] exp_pop;
                g = rr_pick(last, preq);
                exp_pop = 4'b0;
                if (g >= 0) exp_pop[g] = 1'b1;
                chk("one_pop", $countones(popv), 1);
                chk("grant", popv, exp_pop);
                chk("pop_while_valid", bus.valid_out, 0);
                pk = 0;
                for (int k = 0; k < 4; k++) if (popv[k]) pk = k;
                chk("pop_nonempty", expq[pk].size() > 0, 1);
                if (expq[pk].size() > 0) inf_w = expq[pk].pop_front();
                inf_k = pk; have_inf = 1; npops++;
            end
            if (pvld && !phs) begin
                chk("hold_valid", bus.valid_out, 1);
                chk("hold_data", bus.data_out, pdata);
                chk("hold_origen", bus.origen, porig);
            end
            phs = bus.valid_out && rdy;
            if (phs) begin
                chk("hs_pending", have_inf, 1);
                chk("origen", bus.origen, inf_k);
                chk("data", bus.data_out, inf_w);
                mcnt[inf_k] = mcnt[inf_k] + 8'd1;
                last = inf_k; have_inf = 0; deliv++;
                olog.push_back(int'(bus.origen));
            end
            pvld = bus.valid_out; pdata = bus.data_out; porig = bus.origen;
        end
        preq = ~emp;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic push(input int k, input logic [5:0] w);
        fq[k].push_back(w);
        expq[k].push_back(w);
    endtask

    task automatic wait_deliv(input int n, input int budget);
        int c = 0;
        while (deliv < n && c < budget) begin @(negedge clk); c++; end
        if (deliv < n) chk("timeout_deliv", deliv, n);
    endtask

    task automatic wait_valid(input int budget);
        int c = 0;
        @(negedge clk);
        while (!bus.valid_out && c < budget) begin @(negedge clk); c++; end
        if (!bus.valid_out) chk("timeout_valid", bus.valid_out, 1);
    endtask

    initial begin
        logic [5:0] w40, w;
        logic [15:0] seq;
        int base, c;
        for (int k = 0; k < 4; k++) rd[k] = '0;

        // Reset with all FIFOs loaded (2 words each)
        rdy = 1'b1;
        tick(); tick();
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 4; k++) push(k, 6'($urandom));
        w40 = fq[0][0];
        tick(); tick();
        @(negedge clk);
        chk("rst_pop", popv, 0);
        chk("rst_valid", bus.valid_out, 0);
        chk("rst_data", bus.data_out, 0);
        chk("rst_origen", bus.origen, 0);
        chk("rst_cnt", cntv, 0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        @(negedge clk); chk("pop4_latency", popv, 4'b0001);
        @(negedge clk); chk("capture_novalid", bus.valid_out, 0);
        @(negedge clk);
        chk("first_valid", bus.valid_out, 1);
        chk("first_origen", bus.origen, 0);
        chk("first_data", bus.data_out, w40);

        wait_deliv(8, 200);
        @(negedge clk);
        seq = '0;
        for (int i = 0; i < 8 && i < olog.size(); i++) seq = {seq[13:0], 2'(olog[i])};
        chk("rr_sequence", seq, 16'h1B1B);
        chk("pop_count", npops, 8);
        chk("cnt_after_rr", cntv, {8'd2, 8'd2, 8'd2, 8'd2});

        // Backpressure on a lone FIFO6 word
        tick(); rdy = 1'b0;
        push(2, 6'h2A);
        base = deliv;
        wait_valid(50);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", bus.valid_out, 1);
            chk("bp_data", bus.data_out, 6'h2A);
            @(posedge clk); #1;
            if (i == 4) rdy = 1'b1;
            @(negedge clk);
        end
        chk("bp_valid6", bus.valid_out, 1);
        chk("bp_data6", bus.data_out, 6'h2A);
        wait_deliv(base + 1, 20);
        @(negedge clk);
        chk("cnt_after_bp", cntv, {8'd2, 8'd3, 8'd2, 8'd2});

        // FIFO7 arrives while a FIFO4 word sits in SEND
        tick(); rdy = 1'b0;
        push(0, 6'h11);
        base = deliv;
        wait_valid(50);
        tick(); push(3, 6'h37);
        repeat (4) tick();
        @(negedge clk);
        chk("no_pop_in_send", popv, 0);
        chk("held_origen4", bus.origen, 0);
        tick(); rdy = 1'b1;
        wait_deliv(base + 2, 100);
        @(negedge clk);
        chk("late_origen7", olog[olog.size()-1], 3);
        chk("cnt_after_late", cntv, {8'd3, 8'd3, 8'd2, 8'd3});

        // Reset during SEND
        tick(); rdy = 1'b0;
        push(1, 6'h15);
        wait_valid(50);
        tick(); rst = 1'b1; #1;
        chk("async_valid", bus.valid_out, 0);
        chk("async_pop", popv, 0);
        chk("async_cnt", cntv, 0);
        push(1, 6'h25); push(0, 6'h05);
        repeat (3) tick();
        rst = 1'b0; rdy = 1'b1;
        base = deliv;
        wait_deliv(base + 2, 100);
        @(negedge clk);
        chk("post_rst_first", olog[olog.size()-2], 0);
        chk("post_rst_second", olog[olog.size()-1], 1);
        chk("cnt_post_rst", cntv, {8'd0, 8'd0, 8'd1, 8'd1});

        // Random traffic and backpressure
        for (int i = 0; i < 400; i++) begin
            tick();
            if ($urandom_range(0, 3) == 0) begin
                w = 6'($urandom);
                push($urandom_range(0, 3), w);
            end
            rdy = ($urandom_range(0, 3) != 0);
        end
        tick(); rdy = 1'b1;
        c = 0;
        while ((fq[0].size() + fq[1].size() + fq[2].size() + fq[3].size() +
                expq[0].size() + expq[1].size() + expq[2].size() + expq[3].size() != 0 ||
                have_inf || bus.valid_out || popv != 4'b0) && c < 2000) begin
            @(negedge clk); c++;
        end
        chk("drain", c < 2000, 1);
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) chk("rand_cnt", cntv[k], mcnt[k]);

        // Counter wrap on FIFO5
        tick(); rst = 1'b1;
        tick(); tick();
        for (int i = 0; i < 256; i++) push(1, 6'(i));
        tick(); tick();
        rst = 1'b0;
        base = deliv;
        wait_deliv(base + 256, 1500);
        repeat (2) @(negedge clk);
        chk("cnt5_wrap", cntv[1], 8'd0);
        chk("cnt_others_wrap", {cntv[3], cntv[2], cntv[0]}, 24'd0);
        chk("wrap_model", cntv[1], mcnt[1]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
